vm2002_coin_acceptor: RTL

- Front-end credit stage of the vm2002 vending machine. Sits directly upstream of the vend controller.
- Validates inserted coins (coins_t) and accumulates customer credit in cents.
- Serves debit requests from the vend controller when an item is bought.
- On a refund request, returns the remaining credit as change, one coin per handshake, largest denomination first.

---
 rtl/vm2002_pkg.sv | 34 +++
 rtl/vm2002_change_sel.sv | 20 ++
 rtl/vm2002_coin_acceptor.sv | 131 +++++++++++++
 3 files changed

// File: rtl/vm2002_pkg.sv
// Shared types and helpers for the vm2002 vending machine credit path.
package vm2002_pkg;

    localparam int unsigned NICKEL_CENTS  = 5;
    localparam int unsigned DIME_CENTS    = 10;
    localparam int unsigned QUARTER_CENTS = 25;

    // Wide enough for the largest coin denomination.
    localparam int unsigned COIN_W = 5;

    typedef enum logic [1:0] {
        NICKEL      = 2'd0,
        DIME        = 2'd1,
        QUARTER     = 2'd2,
        ILLEGALCOIN = 2'd3
    } coins_t;

    typedef enum logic {
        IDLE   = 1'b0,
        REFUND = 1'b1
    } acceptor_state_t;

    function automatic logic [COIN_W-1:0] coin_value(input coins_t c);
        logic [COIN_W-1:0] v;
        unique case (c)
            NICKEL:  v = COIN_W'(NICKEL_CENTS);
            DIME:    v = COIN_W'(DIME_CENTS);
            QUARTER: v = COIN_W'(QUARTER_CENTS);
            default: v = '0;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/vm2002_change_sel.sv
// Greedy change picker: largest coin not exceeding the outstanding credit.
module vm2002_change_sel
    import vm2002_pkg::*;
#(
    parameter int unsigned CREDIT_W = 9
) (
    input  logic [CREDIT_W-1:0] credit,
    output coins_t              change_coin
);

    always_comb begin
        change_coin = NICKEL;
        if (credit >= CREDIT_W'(QUARTER_CENTS)) begin
            change_coin = QUARTER;
        end else if (credit >= CREDIT_W'(DIME_CENTS)) begin
            change_coin = DIME;
        end
    end

endmodule

// File: rtl/vm2002_coin_acceptor.sv
// Coin validation, credit accumulation, debit service and coin-by-coin refund.
module vm2002_coin_acceptor
    import vm2002_pkg::*;
#(
    parameter int unsigned CREDIT_W   = 9,
    parameter int unsigned MAX_CREDIT = 300
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                coin_valid,
    input  coins_t              coin,
    output logic                coin_accept,
    output logic                coin_reject,
    output logic [CREDIT_W-1:0] credit,
    input  logic                debit_valid,
    input  logic [CREDIT_W-1:0] debit_amount,
    output logic                debit_ok,
    output logic                debit_err,
    input  logic                refund_req,
    output logic                change_valid,
    output coins_t              change_coin,
    input  logic                change_ack,
    output logic                busy
);

    localparam int unsigned SUM_W = CREDIT_W + 1;

    acceptor_state_t     state_q, state_d;
    logic [CREDIT_W-1:0] credit_q, credit_d;
    logic                coin_accept_q, coin_accept_d;
    logic                coin_reject_q, coin_reject_d;
    logic                debit_ok_q, debit_ok_d;
    logic                debit_err_q, debit_err_d;

    coins_t              sel_coin;
    logic [SUM_W-1:0]    coin_sum;
    logic                coin_ok;
    logic                debit_good;
    logic [CREDIT_W-1:0] refund_rem;
    logic [SUM_W-1:0]    idle_next;

    vm2002_change_sel #(
        .CREDIT_W(CREDIT_W)
    ) u_change_sel (
        .credit      (credit_q),
        .change_coin (sel_coin)
    );

    // Ceiling check is one bit wider than the credit so it cannot wrap.
    assign coin_sum   = SUM_W'(credit_q) + SUM_W'(coin_value(coin));
    assign coin_ok    = (coin != ILLEGALCOIN) && (coin_sum <= SUM_W'(MAX_CREDIT));
    assign debit_good = (debit_amount != '0) && (debit_amount <= credit_q) &&
                        ((debit_amount % CREDIT_W'(NICKEL_CENTS)) == '0);
    assign refund_rem = credit_q - CREDIT_W'(coin_value(sel_coin));

    always_comb begin
        state_d       = state_q;
        credit_d      = credit_q;
        coin_accept_d = 1'b0;
        coin_reject_d = 1'b0;
        debit_ok_d    = 1'b0;
        debit_err_d   = 1'b0;
        idle_next     = SUM_W'(credit_q);

        unique case (state_q)
            IDLE: begin
                if (coin_valid) begin
                    if (coin_ok) begin
                        coin_accept_d = 1'b1;
                        idle_next     = coin_sum;
                    end else begin
                        coin_reject_d = 1'b1;
                    end
                end
                // Debit is judged on the pre-cycle credit, so a coin arriving
                // in the same cycle can never fund it.
                if (debit_valid) begin
                    if (debit_good) begin
                        debit_ok_d = 1'b1;
                        idle_next  = idle_next - SUM_W'(debit_amount);
                    end else begin
                        debit_err_d = 1'b1;
                    end
                end
                credit_d = CREDIT_W'(idle_next);
                if (refund_req && (idle_next != '0)) begin
                    state_d = REFUND;
                end
            end
            REFUND: begin
                coin_reject_d = coin_valid;
                debit_err_d   = debit_valid;
                if (change_ack) begin
                    credit_d = refund_rem;
                    if (refund_rem == '0) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            credit_q      <= '0;
            coin_accept_q <= 1'b0;
            coin_reject_q <= 1'b0;
            debit_ok_q    <= 1'b0;
            debit_err_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            credit_q      <= credit_d;
            coin_accept_q <= coin_accept_d;
            coin_reject_q <= coin_reject_d;
            debit_ok_q    <= debit_ok_d;
            debit_err_q   <= debit_err_d;
        end
    end

    assign coin_accept  = coin_accept_q;
    assign coin_reject  = coin_reject_q;
    assign debit_ok     = debit_ok_q;
    assign debit_err    = debit_err_q;
    assign credit       = credit_q;
    assign busy         = (state_q == REFUND);
    assign change_valid = (state_q == REFUND);
    assign change_coin  = (state_q == REFUND) ? sel_coin : NICKEL;

endmodule
